word_to_pixel_unpacker: RTL and testbench
=========================================

WORD_TO_PIXEL_UNPACKER -- requirements
Module: word_to_pixel_unpacker

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line used for coordinate wrap (legal 1..65535).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = first pixel in in_data[31:24]; 0 = first pixel in in_data[7:0].
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_ready out 1, in_valid in 1, in_data in 32, in_startofpacket in 1, in_endofpacket in 1, in_empty in 2: Avalon-ST word sink fed by the FIFO stage.
REQ-006 SHALL have ports out_ready in 1, out_valid out 1, out_data out 8, out_startofpacket out 1, out_endofpacket out 1: Avalon-ST pixel source.
REQ-007 SHALL have ports out_x out 16 and out_y out 16: column/row of the pixel currently presented.
REQ-008 SHALL have port frame_err out 1: one-cycle pulse on a malformed frame end.

Function
REQ-009 SHALL hold at most one word (data, sop, eop, empty) plus a 2-bit byte index; state is EMPTY (no word held) or EMIT (word held).
REQ-010 SHALL transfer on in_valid&&in_ready; SHALL transfer pixel on out_valid&&out_ready.
REQ-011 SHALL drive in_ready = EMPTY || (out_ready && index==last), last = eop ? 3-empty : 3; back-to-back words sustain one pixel per cycle.
REQ-012 SHALL capture an accepted word at edge N, index=0, out_valid=1 from cycle N+1 (latency 1 cycle).
REQ-013 SHALL drive out_valid = EMIT; out_data = byte[index] per MSB_FIRST; unaffected by out_ready.
REQ-014 SHALL hold out_data/out_* stable while out_valid && !out_ready.
REQ-015 SHALL increment index on each pixel transfer; at index==last the transfer SHALL either load a concurrently accepted word (index=0, stay EMIT) or go EMPTY.
REQ-016 SHALL assert out_startofpacket only at index==0 of a sop word, out_endofpacket only at index==last of an eop word.
REQ-017 SHALL ignore in_empty on non-eop words; eop with empty=3 emits exactly one pixel.
REQ-018 SHALL set out_x/out_y to 0/0 for a sop pixel; per transfer x++, at x==IMG_WIDTH-1 x=0 and y++ (y wraps 65535->0).
REQ-019 SHALL reset x/y to 0 after an eop pixel transfer.
REQ-020 SHALL pulse frame_err the cycle after an eop pixel transfers with x != IMG_WIDTH-1, or a sop pixel transfers while x!=0 or y!=0.
REQ-021 SHALL still pass pixels unchanged when frame_err fires; no drop, no stall.

Reset
REQ-022 SHALL on reset_n low, asynchronously: state EMPTY, index 0, x=y=0, out_valid=0, out_startofpacket=0, out_endofpacket=0, frame_err=0, out_data=0, in_ready=1 after release.
REQ-023 SHALL discard any held partial word on reset mid-word; no pixel of it emitted after release.

Structure
REQ-024 SHALL take WORD_W=32, PIXEL_W=8, EMPTY_W=2, COORD_W=16 and state encoding from shared package img_stream_pkg.
REQ-025 SHALL place x/y counting and frame_err detection in one sub-module pixel_coord_counter; word hold and byte select stay top-level.

Verification
REQ-026 Word 0xAABBCCDD sop=1 eop=0, out_ready=1, MSB_FIRST=1 -> pixels AA,BB,CC,DD on 4 consecutive cycles, sop on AA only, x=0..3.
REQ-027 Two words back-to-back, out_ready=1 -> 8 pixels in 8 consecutive cycles, in_ready high in cycle of 4th pixel, no bubble.
REQ-028 Eop word 0x11223344 empty=2 -> pixels 11,22 only, eop on 22, then EMPTY, x=y=0.
REQ-029 out_ready toggled 1010 during word -> each pixel held stable while stalled, order preserved, in_ready=0 until last pixel transfers.
REQ-030 IMG_WIDTH=4, 3 words sop..eop empty=2 (10 px) -> y reaches 2, frame_err pulses once after eop (x=1); 12-pixel frame -> no pulse.
REQ-031 reset_n low after 2nd pixel of held word -> out_valid=0 immediately, after release next word starts at index 0 with x=y=0.

Source files
------------

// File: rtl/img_stream_pkg.sv
// img_stream_pkg: widths, word-hold state encoding and byte-index helper shared by the pixel stream blocks.
package img_stream_pkg;
    localparam int WORD_W  = 32;
    localparam int PIXEL_W = 8;
    localparam int EMPTY_W = 2;
    localparam int COORD_W = 16;

    typedef enum logic {ST_EMPTY, ST_EMIT} state_t;

    function automatic logic [1:0] last_index(input logic eop, input logic [EMPTY_W-1:0] empty);
        return eop ? 2'(2'd3 - empty) : 2'd3;
    endfunction
endpackage

// File: rtl/pixel_coord_counter.sv
// pixel_coord_counter: tracks the x/y position of the presented pixel and flags malformed frame boundaries.
module pixel_coord_counter
    import img_stream_pkg::*;
#(
    parameter int IMG_WIDTH = 640
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fire,
    input  logic               pix_sop,
    input  logic               pix_eop,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_err
);
    logic [COORD_W-1:0] cnt_x, cnt_y;
    logic               last_col;

    // a sop pixel always sits at the origin, whatever the counter says
    always_comb begin
        x        = pix_sop ? '0 : cnt_x;
        y        = pix_sop ? '0 : cnt_y;
        last_col = x == COORD_W'(IMG_WIDTH - 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_x     <= '0;
            cnt_y     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= fire && ((pix_eop && !last_col) || (pix_sop && (cnt_x != '0 || cnt_y != '0)));
            if (fire) begin
                cnt_x <= (pix_eop || last_col) ? '0 : x + 1'b1;
                cnt_y <= pix_eop ? '0 : (last_col ? y + 1'b1 : y);
            end
        end
    end
endmodule

// File: rtl/word_to_pixel_unpacker.sv
// word_to_pixel_unpacker: holds one 32-bit Avalon-ST word and emits it as 8-bit pixels with x/y coordinates.
module word_to_pixel_unpacker
    import img_stream_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter bit MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               in_ready,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [PIXEL_W-1:0] out_data,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               frame_err
);
    state_t             state;
    logic [WORD_W-1:0]  data;
    logic               sop, eop;
    logic [EMPTY_W-1:0] empty;
    logic [1:0]         index, sel;
    logic               at_last, accept, fire;

    always_comb begin
        at_last           = index == last_index(eop, empty);
        out_valid         = state == ST_EMIT;
        in_ready          = state == ST_EMPTY || (out_ready && at_last);
        accept            = in_valid && in_ready;
        fire              = out_valid && out_ready;
        sel               = MSB_FIRST ? 2'(2'd3 - index) : index;
        out_data          = data[{sel, 3'b000} +: PIXEL_W];
        out_startofpacket = out_valid && sop && index == 2'd0;
        out_endofpacket   = out_valid && eop && at_last;
    end

    // a new word only lands while empty or on the final pixel's transfer, so load wins over advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
            index <= 2'd0;
            data  <= '0;
            sop   <= 1'b0;
            eop   <= 1'b0;
            empty <= '0;
        end else if (accept) begin
            state <= ST_EMIT;
            index <= 2'd0;
            data  <= in_data;
            sop   <= in_startofpacket;
            eop   <= in_endofpacket;
            empty <= in_empty;
        end else if (fire) begin
            state <= at_last ? ST_EMPTY : ST_EMIT;
            index <= at_last ? 2'd0 : index + 2'd1;
        end
    end

    pixel_coord_counter #(.IMG_WIDTH(IMG_WIDTH)) u_coord (
        .clk       (clk),
        .reset_n   (reset_n),
        .fire      (fire),
        .pix_sop   (out_startofpacket),
        .pix_eop   (out_endofpacket),
        .x         (out_x),
        .y         (out_y),
        .frame_err (frame_err)
    );
endmodule

// File: tb/tb_word_to_pixel_unpacker.sv
// tb_word_to_pixel_unpacker: scoreboard bench; a word-level model queues expected pixels, a monitor checks them.
module tb_word_to_pixel_unpacker;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_ready, in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_startofpacket = 1'b0, in_endofpacket = 1'b0;
    logic [1:0]  in_empty = '0;
    logic        out_ready = 1'b1, out_valid;
    logic [7:0]  out_data;
    logic        out_startofpacket, out_endofpacket, frame_err;
    logic [15:0] out_x, out_y;

    always #5 clk = ~clk;

    word_to_pixel_unpacker #(.IMG_WIDTH(W), .MSB_FIRST(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_empty(in_empty),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_x(out_x), .out_y(out_y), .frame_err(frame_err)
    );

    typedef struct {
        logic [7:0] d;
        logic       sop, eop, last, err;
        int         x, y;
    } pix_t;

    pix_t q[$];
    int   pass_cnt = 0, total = 0;
    int   nx = 0, ny = 0;
    int   ready_mode = 0;
    logic pend_err = 1'b0, prev_stall = 1'b0, tog = 1'b0;
    logic [41:0] snap;

    function automatic void chk(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endfunction

    // expand a word into its pixels in stream order and walk the frame position
    function automatic void model_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
        int n = e ? 4 - int'(emp) : 4;
        for (int i = 0; i < n; i++) begin
            pix_t p;
            logic sop_bad;
            p.d    = d[8*(3-i) +: 8];
            p.sop  = s && i == 0;
            p.eop  = e && i == n - 1;
            p.last = i == n - 1;
            sop_bad = p.sop && (nx != 0 || ny != 0);
            p.x    = p.sop ? 0 : nx;
            p.y    = p.sop ? 0 : ny;
            p.err  = sop_bad || (p.eop && p.x != W - 1);
            if (p.eop) begin nx = 0; ny = 0; end
            else if (p.x + 1 == W) begin nx = 0; ny = (p.y + 1) % 65536; end
            else begin nx = p.x + 1; ny = p.y; end
            q.push_back(p);
        end
    endfunction

    task automatic send_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
        bit acc = 0;
        int n = 0;
        in_valid = 1'b1; in_data = d; in_startofpacket = s; in_endofpacket = e; in_empty = emp;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); n++;
        end while (!acc && n < 200);
        if (acc) model_word(d, s, e, emp);
        else chk("accept_timeout", 0, 1);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 500) begin @(posedge clk); n++; end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk); #1;
        tog = ~tog;
        out_ready = ready_mode == 0 ? 1'b1 : (ready_mode == 1 ? tog : 1'($urandom_range(0, 1)));
    end

    initial forever begin
        @(negedge clk);
        if (!reset_n) prev_stall = 1'b0;
        else begin
            chk("frame_err", frame_err, pend_err);
            pend_err = 1'b0;
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() == 0 || (out_ready && q[0].last));
            if (prev_stall)
                chk("stall_hold", {out_data, out_startofpacket, out_endofpacket, out_x, out_y}, snap);
            if (out_valid && q.size() > 0) begin
                chk("data", out_data, q[0].d);
                chk("sop", out_startofpacket, q[0].sop);
                chk("eop", out_endofpacket, q[0].eop);
                chk("x", out_x, q[0].x);
                chk("y", out_y, q[0].y);
                if (out_ready) begin
                    pend_err = q[0].err;
                    void'(q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            snap = {out_data, out_startofpacket, out_endofpacket, out_x, out_y};
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sop", out_startofpacket, 0);
        chk("rst_eop", out_endofpacket, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_data", out_data, 0);
        chk("rst_xy", {out_x, out_y}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        send_word(32'hAABBCCDD, 1, 0, 0);
        drain();
        send_word(32'h01020304, 1, 0, 0);
        send_word(32'h05060708, 0, 0, 3);
        drain();
        send_word(32'h11223344, 0, 1, 2);
        drain();
        chk("post_eop_xy", {out_x, out_y}, 0);
        chk("post_eop_valid", out_valid, 0);

        ready_mode = 1;
        send_word(32'hDEADBEEF, 1, 0, 0);
        send_word(32'hCAFEF00D, 0, 0, 0);
        drain();
        ready_mode = 0;

        send_word(32'h10203040, 1, 0, 0);
        send_word(32'h50607080, 0, 0, 0);
        send_word(32'h90A0B0C0, 0, 1, 2);
        drain();
        send_word(32'h0A0B0C0D, 1, 0, 0);
        send_word(32'h1A1B1C1D, 0, 0, 0);
        send_word(32'h2A2B2C2D, 0, 1, 0);
        drain();

        send_word(32'hA1B2C3D4, 1, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b0;
        q.delete(); nx = 0; ny = 0; pend_err = 1'b0;
        #1;
        chk("midword_rst_valid", out_valid, 0);
        chk("midword_rst_xy", {out_x, out_y}, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        send_word(32'h55667788, 0, 0, 0);
        drain();

        ready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send_word($urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
